// File: rtl/bch31_serial_encoder.sv
// ---------------------------------------------------------------------------
// bch31_serial_encoder
//   Systematic serial BCH(31,21), t=2 encoder over GF(2^5). Message bits
//   arrive one per handshake, highest degree first, and are passed straight
//   through to the output stream while a 10-bit LFSR divides m(x)*x^10 by
//   g(x) = x^10+x^9+x^8+x^6+x^5+x^3+1. After the 21st message bit the
//   remainder is shifted out MSB first as the 10 parity bits.
//
// Ports
//   clk        clock
//   rst        asynchronous reset, active-low
//   in_valid   message bit valid
//   in_bit     message bit
//   in_ready   encoder accepts in_bit this cycle
//   out_valid  out_bit valid
//   out_bit    codeword bit
//   out_first  marks the first codeword bit (degree 30)
//   out_last   marks the last parity bit (degree 0)
//   out_ready  downstream accepts out_bit this cycle
//   busy       a codeword is in progress
// ---------------------------------------------------------------------------
module bch31_serial_encoder #(
  parameter int          K   = 21,
  parameter int          NP  = 10,
  parameter logic [NP:0] GEN = 11'h769
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_first,
  output logic out_last,
  input  logic out_ready,
  output logic busy
);

  localparam int MSG_W = $clog2(K + 1);
  localparam int PAR_W = $clog2(NP + 1);
  localparam logic [MSG_W-1:0] MSG_LAST = MSG_W'(K - 1);
  localparam logic [PAR_W-1:0] PAR_LAST = PAR_W'(NP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MSG  = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NP-1:0]    r_rem;
  logic [MSG_W-1:0] r_msg_cnt;
  logic [PAR_W-1:0] r_par_cnt;
  logic             r_out_valid;
  logic             r_out_bit;
  logic             r_out_first;
  logic             r_out_last;

  logic w_slot_free;
  logic w_accept;
  logic w_par_shift;
  logic w_msg_done;
  logic w_par_done;

  // One division step of the remainder register by g(x); g10 is implicit.
  function automatic logic [NP-1:0] lfsr_step(input logic [NP-1:0] rem,
                                              input logic           m);
    logic fb;
    fb = m ^ rem[NP-1];
    return {rem[NP-2:0], 1'b0} ^ (fb ? GEN[NP-1:0] : '0);
  endfunction

  // The output register can take a new bit when empty or being drained now.
  assign w_slot_free = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_par_shift = (r_state == S_PAR) && w_slot_free;
  assign w_msg_done  = (r_msg_cnt == MSG_LAST);
  assign w_par_done  = (r_par_cnt == PAR_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_MSG;
      S_MSG:   if (w_accept && w_msg_done) w_state_nxt = S_PAR;
      S_PAR:   if (w_slot_free && w_par_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic; in_ready and busy are forced low while reset is held.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    if (rst) begin
      in_ready = w_slot_free && (r_state != S_PAR);
      busy     = (r_state != S_IDLE) || r_out_valid;
    end
  end

  // Datapath: LFSR, counters and the single output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem       <= '0;
      r_msg_cnt   <= '0;
      r_par_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_rem       <= lfsr_step(r_rem, in_bit);
      r_out_valid <= 1'b1;
      r_out_bit   <= in_bit;
      r_out_first <= (r_state == S_IDLE);
      r_out_last  <= 1'b0;
      r_msg_cnt   <= (r_state == S_IDLE) ? MSG_W'(1) : r_msg_cnt + MSG_W'(1);
      if (r_state == S_MSG && w_msg_done) begin
        r_par_cnt <= '0;
      end
    end else if (w_par_shift) begin
      // Parity leaves MSB first; the register is all zero after the last shift.
      r_rem       <= {r_rem[NP-2:0], 1'b0};
      r_out_valid <= 1'b1;
      r_out_bit   <= r_rem[NP-1];
      r_out_first <= 1'b0;
      r_out_last  <= w_par_done;
      r_par_cnt   <= w_par_done ? '0 : r_par_cnt + PAR_W'(1);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_bit;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_bch31_serial_encoder.sv
// ---------------------------------------------------------------------------
// tb_bch31_serial_encoder
//   Self-checking bench for bch31_serial_encoder. Expected codewords come
//   from polynomial long division of m(x)*x^10 by g(x); received codewords
//   are also checked for zero syndromes at alpha and alpha^3 in GF(2^5).
// ---------------------------------------------------------------------------
module tb_bch31_serial_encoder;

  localparam logic [10:0] G = 11'h769;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_bit;
  logic out_first;
  logic out_last;
  logic out_ready = 1'b0;
  logic busy;

  int total = 0;
  int bad   = 0;

  logic msg_q[$];
  logic rx[$];
  logic rxf[$];
  logic rxl[$];
  int   cycles;
  int   stall_bad;
  int   par_bad;

  bch31_serial_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Remainder of a degree<=30 polynomial modulo g(x) by long division.
  function automatic logic [9:0] poly_mod(input logic [30:0] c);
    logic [30:0] r;
    r = c;
    for (int d = 30; d >= 10; d--) begin
      if (r[d]) r = r ^ (31'(G) << (d - 10));
    end
    return r[9:0];
  endfunction

  function automatic logic [9:0] ref_parity(input logic [20:0] m);
    return poly_mod({m, 10'b0});
  endfunction

  // GF(2^5) multiply, field polynomial x^5+x^2+1.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] p;
    logic [4:0] aa;
    p  = 5'd0;
    aa = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[4] ? ({aa[3:0], 1'b0} ^ 5'h05) : {aa[3:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [4:0] syndrome(input logic [30:0] c, input logic [4:0] beta);
    logic [4:0] s;
    s = 5'd0;
    for (int d = 30; d >= 0; d--) s = gf_mul(s, beta) ^ {4'b0, c[d]};
    return s;
  endfunction

  function automatic logic [30:0] get_vec(input int f, input int which);
    logic [30:0] v;
    v = '0;
    for (int j = 0; j < 31; j++) begin
      if (f * 31 + j < rx.size()) begin
        case (which)
          0:       v[30-j] = rx[f*31+j];
          1:       v[30-j] = rxf[f*31+j];
          default: v[30-j] = rxl[f*31+j];
        endcase
      end else begin
        v[30-j] = 1'bx;
      end
    end
    return v;
  endfunction

  task automatic push_msg(input logic [20:0] m);
    for (int i = 20; i >= 0; i--) msg_q.push_back(m[i]);
  endtask

  // Streams every bit of msg_q through the DUT and records the output stream.
  task automatic run_stream(input int pv, input int pr, input int max_cyc);
    int   acc;
    int   nlast;
    int   nbits;
    int   target;
    logic pstall, pbit, pfirst, plast;
    logic v, r;
    nbits  = msg_q.size();
    target = (nbits / 21) * 31;
    rx.delete(); rxf.delete(); rxl.delete();
    acc = 0; nlast = 0; pstall = 0; pbit = 0; pfirst = 0; plast = 0;
    cycles = 0; stall_bad = 0; par_bad = 0;
    while (rx.size() < target && cycles < max_cyc) begin
      r = ($urandom_range(0, 99) < pr);
      v = (acc < nbits) && ($urandom_range(0, 99) < pv);
      @(negedge clk);
      out_ready = r;
      in_valid  = v;
      in_bit    = v ? msg_q[acc] : 1'($urandom);
      #1;
      if (pstall && !(out_valid && out_bit == pbit && out_first == pfirst && out_last == plast))
        stall_bad++;
      if (acc > 0 && acc % 21 == 0 && nlast < acc / 21 && !(out_valid && out_last) && in_ready)
        par_bad++;
      if (out_valid && r) begin
        rx.push_back(out_bit);
        rxf.push_back(out_first);
        rxl.push_back(out_last);
        if (out_last) nlast++;
      end
      if (v && in_ready) acc++;
      pstall = out_valid && !r;
      pbit   = out_bit;
      pfirst = out_first;
      plast  = out_last;
      cycles++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({out_valid, out_bit, out_first, out_last, in_ready, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {out_valid, out_bit, out_first, out_last, in_ready, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      bad++;
      $display("FAIL idle_after_reset: got %b want 100", {in_ready, busy, out_valid});
    end
  endtask

  task automatic test_all_zero;
    msg_q.delete();
    push_msg(21'h0);
    run_stream(100, 100, 200);
    total++;
    if (cycles != 32 || rx.size() != 31) begin
      bad++;
      $display("FAIL zero_timing: got cycles=%0d bits=%0d want 32/31", cycles, rx.size());
    end
    total++;
    if (get_vec(0, 0) !== 31'h0) begin
      bad++;
      $display("FAIL zero_codeword: got %h want 0", get_vec(0, 0));
    end
    total++;
    if (get_vec(0, 1) !== 31'h4000_0000 || get_vec(0, 2) !== 31'h1) begin
      bad++;
      $display("FAIL zero_flags: got first=%h last=%h want 40000000/1",
               get_vec(0, 1), get_vec(0, 2));
    end
    total++;
    if ({busy, out_valid} !== 2'b00 || dut.r_rem !== 10'h0) begin
      bad++;
      $display("FAIL zero_end_state: got busy=%b vld=%b rem=%h want 0/0/0",
               busy, out_valid, dut.r_rem);
    end
  endtask

  task automatic test_single_lsb;
    msg_q.delete();
    push_msg(21'h1);
    run_stream(100, 100, 200);
    total++;
    if (get_vec(0, 0) !== {21'h1, 10'b1101101001}) begin
      bad++;
      $display("FAIL lsb_codeword: got %h want %h", get_vec(0, 0), {21'h1, 10'b1101101001});
    end
  endtask

  task automatic test_single_msb;
    logic [30:0] cw;
    msg_q.delete();
    push_msg(21'h100000);
    run_stream(100, 100, 200);
    cw = get_vec(0, 0);
    total++;
    if (cw !== {21'h100000, ref_parity(21'h100000)}) begin
      bad++;
      $display("FAIL msb_codeword: got %h want %h", cw, {21'h100000, ref_parity(21'h100000)});
    end
    total++;
    if (poly_mod(cw) !== 10'h0) begin
      bad++;
      $display("FAIL msb_divisible: got rem %h want 0", poly_mod(cw));
    end
    total++;
    if (syndrome(cw, 5'b00010) !== 5'h0 || syndrome(cw, 5'b01000) !== 5'h0) begin
      bad++;
      $display("FAIL msb_syndromes: got S1=%h S3=%h want 0/0",
               syndrome(cw, 5'b00010), syndrome(cw, 5'b01000));
    end
  endtask

  task automatic test_random;
    logic [20:0] msgs[6];
    logic [30:0] cw;
    msg_q.delete();
    for (int f = 0; f < 6; f++) begin
      msgs[f] = 21'($urandom);
      push_msg(msgs[f]);
    end
    run_stream(70, 50, 4000);
    total++;
    if (rx.size() != 186) begin
      bad++;
      $display("FAIL random_timeout: got %0d bits want 186", rx.size());
    end
    for (int f = 0; f < 6; f++) begin
      cw = get_vec(f, 0);
      total++;
      if (cw !== {msgs[f], ref_parity(msgs[f])}) begin
        bad++;
        $display("FAIL random_cw%0d: got %h want %h", f, cw, {msgs[f], ref_parity(msgs[f])});
      end
      total++;
      if (get_vec(f, 1) !== 31'h4000_0000 || get_vec(f, 2) !== 31'h1 ||
          syndrome(cw, 5'b00010) !== 5'h0 || syndrome(cw, 5'b01000) !== 5'h0) begin
        bad++;
        $display("FAIL random_flags_syn%0d: got first=%h last=%h S1=%h S3=%h want 40000000/1/0/0",
                 f, get_vec(f, 1), get_vec(f, 2), syndrome(cw, 5'b00010), syndrome(cw, 5'b01000));
      end
    end
    total++;
    if (stall_bad != 0) begin
      bad++;
      $display("FAIL random_stall_hold: got %0d changes want 0", stall_bad);
    end
    total++;
    if (par_bad != 0) begin
      bad++;
      $display("FAIL random_ready_in_par: got %0d cycles want 0", par_bad);
    end
  endtask

  task automatic test_back_to_back;
    logic [20:0] m0, m1;
    m0 = 21'($urandom);
    m1 = 21'($urandom);
    msg_q.delete();
    push_msg(m0);
    push_msg(m1);
    run_stream(100, 100, 300);
    total++;
    if (cycles != 63 || rx.size() != 62) begin
      bad++;
      $display("FAIL b2b_gapless: got cycles=%0d bits=%0d want 63/62", cycles, rx.size());
    end
    total++;
    if (get_vec(0, 0) !== {m0, ref_parity(m0)} || get_vec(1, 0) !== {m1, ref_parity(m1)}) begin
      bad++;
      $display("FAIL b2b_codewords: got %h %h want %h %h", get_vec(0, 0), get_vec(1, 0),
               {m0, ref_parity(m0)}, {m1, ref_parity(m1)});
    end
    total++;
    if (get_vec(0, 2) !== 31'h1 || get_vec(1, 1) !== 31'h4000_0000) begin
      bad++;
      $display("FAIL b2b_flags: got last0=%h first1=%h want 1/40000000",
               get_vec(0, 2), get_vec(1, 1));
    end
  endtask

  task automatic test_reset_mid;
    logic [20:0] m;
    int acc;
    int guard;
    m = 21'($urandom);
    acc = 0;
    guard = 0;
    while (acc < 12 && guard < 200) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_bit    = m[20-acc];
      #1;
      if (in_ready) acc++;
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || acc != 12) begin
      bad++;
      $display("FAIL mid_busy: got busy=%b accepted=%0d want 1/12", busy, acc);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_bit, out_first, out_last, in_ready, busy} !== 6'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got %b want 000000",
               {out_valid, out_bit, out_first, out_last, in_ready, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    msg_q.delete();
    push_msg(21'h155555);
    run_stream(100, 100, 200);
    total++;
    if (get_vec(0, 0) !== {21'h155555, ref_parity(21'h155555)} || get_vec(0, 1) !== 31'h4000_0000) begin
      bad++;
      $display("FAIL mid_next_frame: got %h first=%h want %h first=40000000",
               get_vec(0, 0), get_vec(0, 1), {21'h155555, ref_parity(21'h155555)});
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_lsb();
    test_single_msb();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
